census_hamming_cost: RTL and testbench



---
 rtl/census_hamming_cost.sv | 105 ++++++++++
 tb/tb_census_hamming_cost.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/census_hamming_cost.sv
// Census matching cost: Hamming distance between each left census vector and the
// DispN most recent right vectors of the same line, as a 2-stage streaming pipeline.
module census_hamming_cost #(
  parameter int CVW   = 8,
  parameter int DispN = 16,
  parameter int CostW = $clog2(CVW + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sol,
  input  logic [CVW-1:0]         cvL,
  input  logic [CVW-1:0]         cvR,
  output logic                   out_valid,
  output logic                   out_sol,
  output logic [DispN*CostW-1:0] out_cost
);

  // Handshake: in_valid qualifies cvL/cvR/in_sol for exactly one cycle and is always
  // accepted; out_valid marks out_cost/out_sol valid for one cycle, with no stall path.

  localparam int ColW = (DispN > 1) ? $clog2(DispN) : 1;
  localparam logic [ColW-1:0] ColMax = ColW'(DispN - 1);

  logic [CVW-1:0]   hist [DispN-1];
  logic [ColW-1:0]  col;
  logic [ColW-1:0]  cur_col;
  logic [CVW-1:0]   cand [DispN];
  logic [CVW-1:0]   x_xor [DispN];
  logic [DispN-1:0] x_mask;

  logic [CVW-1:0]   s1_xor [DispN];
  logic [DispN-1:0] s1_mask;
  logic             s1_sol;
  logic             s1_valid;

  logic [DispN*CostW-1:0] cost_c;

  function automatic logic [CostW-1:0] popcount(input logic [CVW-1:0] v);
    logic [CostW-1:0] n;
    n = '0;
    for (int i = 0; i < CVW; i++) n = n + CostW'(v[i]);
    return n;
  endfunction

  // An sol pixel is column 0 regardless of what the history still holds.
  always_comb begin
    cur_col = in_sol ? '0 : col;
    cand[0] = cvR;
    for (int d = 1; d < DispN; d++) cand[d] = hist[d-1];
    x_mask = '0;
    for (int d = 0; d < DispN; d++) begin
      x_xor[d]  = cvL ^ cand[d];
      x_mask[d] = (d <= int'(cur_col));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      for (int k = 0; k < DispN - 1; k++) hist[k] <= '0;
    end else if (in_valid) begin
      hist[0] <= cvR;
      for (int k = 1; k < DispN - 1; k++) hist[k] <= hist[k-1];
      if (in_sol) col <= ColW'(1);
      else if (col != ColMax) col <= col + ColW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_mask  <= '0;
      for (int d = 0; d < DispN; d++) s1_xor[d] <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sol   <= in_valid & in_sol;
      if (in_valid) begin
        s1_mask <= x_mask;
        for (int d = 0; d < DispN; d++) s1_xor[d] <= x_xor[d];
      end
    end
  end

  // Masked-out candidates report the saturated cost so aggregation never prefers them.
  always_comb begin
    cost_c = '0;
    for (int d = 0; d < DispN; d++)
      cost_c[d*CostW +: CostW] = s1_mask[d] ? popcount(s1_xor[d]) : CostW'(CVW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_cost  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sol   <= s1_valid & s1_sol;
      if (s1_valid) out_cost <= cost_c;
    end
  end

endmodule

// File: tb/tb_census_hamming_cost.sv
// Bench for census_hamming_cost: a default 8/16 instance with directed and random lines,
// plus a 24/64 instance under random traffic, both checked by a line-history model.
module tb_census_hamming_cost;

  localparam int AW = 8,  AD = 16, AC = 4;
  localparam int BW = 24, BD = 64, BC = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  logic            a_in_valid, a_in_sol, a_out_valid, a_out_sol;
  logic [AW-1:0]   a_cvl, a_cvr;
  logic [AD*AC-1:0] a_out_cost;
  logic            b_in_valid, b_in_sol, b_out_valid, b_out_sol;
  logic [BW-1:0]   b_cvl, b_cvr;
  logic [BD*BC-1:0] b_out_cost;

  int n_tests = 0;
  int n_fail  = 0;
  bit b_en    = 1'b1;

  // Expected {sol, cost} and the cycle the pixel was presented.
  logic [AD*AC:0] expa_q[$];
  int             ta_q[$];
  logic [BD*BC:0] expb_q[$];
  int             tb_q[$];
  // Right vectors of the current line, newest first.
  logic [AW-1:0]  a_line[$];
  logic [BW-1:0]  b_line[$];

  census_hamming_cost dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_sol(a_in_sol),
    .cvL(a_cvl), .cvR(a_cvr), .out_valid(a_out_valid), .out_sol(a_out_sol),
    .out_cost(a_out_cost)
  );

  census_hamming_cost #(.CVW(BW), .DispN(BD)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_sol(b_in_sol),
    .cvL(b_cvl), .cvR(b_cvr), .out_valid(b_out_valid), .out_sol(b_out_sol),
    .out_cost(b_out_cost)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  task automatic issue_a(bit sol, logic [AW-1:0] l, logic [AW-1:0] r);
    logic [AD*AC:0] e;
    if (sol) a_line.delete();
    a_line.push_front(r);
    if (a_line.size() > AD) void'(a_line.pop_back());
    e = '0;
    e[AD*AC] = sol;
    for (int d = 0; d < AD; d++)
      e[d*AC +: AC] = (d < a_line.size()) ? AC'($countones(l ^ a_line[d])) : AC'(AW);
    expa_q.push_back(e);
    ta_q.push_back(cyc);
  endtask

  task automatic issue_b(bit sol, logic [BW-1:0] l, logic [BW-1:0] r);
    logic [BD*BC:0] e;
    if (sol) b_line.delete();
    b_line.push_front(r);
    if (b_line.size() > BD) void'(b_line.pop_back());
    e = '0;
    e[BD*BC] = sol;
    for (int d = 0; d < BD; d++)
      e[d*BC +: BC] = (d < b_line.size()) ? BC'($countones(l ^ b_line[d])) : BC'(BW);
    expb_q.push_back(e);
    tb_q.push_back(cyc);
  endtask

  // Driver: presents one cycle of input on both instances, then steps past the edge.
  task automatic pix(bit v, bit sol, logic [AW-1:0] l, logic [AW-1:0] r);
    a_in_valid = v; a_in_sol = sol; a_cvl = l; a_cvr = r;
    b_in_valid = b_en && ($urandom_range(0, 3) != 0);
    b_in_sol   = ($urandom_range(0, 99) == 0);
    b_cvl      = BW'($urandom);
    b_cvr      = ($urandom_range(0, 7) == 0) ? ~b_cvl : BW'($urandom);
    if (rst_n && v) issue_a(sol, l, r);
    if (rst_n && b_in_valid) issue_b(b_in_sol, b_cvl, b_cvr);
    @(posedge clk); #1;
  endtask

  task automatic flush_model();
    expa_q.delete(); ta_q.delete(); a_line.delete();
    expb_q.delete(); tb_q.delete(); b_line.delete();
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [AD*AC:0] e;
    int t;
    if (!rst_n) begin
      n_tests++;
      if (a_out_valid !== 1'b0 || a_out_sol !== 1'b0 || a_out_cost !== '0) begin
        n_fail++;
        $display("FAIL reset_a got valid=%b sol=%b cost=%h want 0/0/0", a_out_valid, a_out_sol, a_out_cost);
      end
    end else if (a_out_valid) begin
      n_tests++;
      if (expa_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_a got cost=%h at cycle %0d want no output", a_out_cost, cyc);
      end else begin
        e = expa_q.pop_front();
        t = ta_q.pop_front();
        if ({a_out_sol, a_out_cost} !== e || cyc != t + 2) begin
          n_fail++;
          $display("FAIL cost_a got %h at cycle %0d want %h at cycle %0d", {a_out_sol, a_out_cost}, cyc, e, t + 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [BD*BC:0] e;
    int t;
    if (!rst_n) begin
      n_tests++;
      if (b_out_valid !== 1'b0 || b_out_cost !== '0) begin
        n_fail++;
        $display("FAIL reset_b got valid=%b cost=%h want 0/0", b_out_valid, b_out_cost);
      end
    end else if (b_out_valid) begin
      n_tests++;
      if (expb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_b got valid at cycle %0d want no output", cyc);
      end else begin
        e = expb_q.pop_front();
        t = tb_q.pop_front();
        if ({b_out_sol, b_out_cost} !== e || cyc != t + 2) begin
          n_fail++;
          $display("FAIL cost_b got %h at cycle %0d want %h at cycle %0d", {b_out_sol, b_out_cost}, cyc, e, t + 2);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sol = 1'b0; a_cvl = '0; a_cvr = '0;
    b_in_valid = 1'b0; b_in_sol = 1'b0; b_cvl = '0; b_cvr = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_sol = 1'($urandom); a_cvl = AW'($urandom); a_cvr = AW'($urandom);
      b_in_valid = 1'b1; b_in_sol = 1'($urandom); b_cvl = BW'($urandom); b_cvr = BW'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    // First pixel after reset is column 0 without sol.
    pix(1'b1, 1'b0, 8'hA5, 8'hA5);
    pix(1'b0, 1'b0, 8'h00, 8'h00);

    // Ramp line, gap-free then with bubbles.
    for (int x = 0; x < 20; x++) pix(1'b1, x == 0, AW'(x), AW'(x));
    for (int x = 0; x < 20; x++) begin
      pix(1'b1, x == 0, AW'(x), AW'(x));
      pix(1'b0, 1'b0, AW'($urandom), AW'($urandom));
    end

    // Line restart, back-to-back sol, and sol without valid.
    for (int i = 0; i < 10; i++) pix(1'b1, 1'b0, AW'($urandom), AW'($urandom));
    pix(1'b1, 1'b1, 8'h00, 8'hFF);
    pix(1'b1, 1'b0, 8'h0F, 8'h0F);
    pix(1'b1, 1'b1, 8'h3C, 8'hC3);
    pix(1'b1, 1'b1, 8'h55, 8'hAA);
    pix(1'b0, 1'b1, 8'hFF, 8'h00);
    pix(1'b1, 1'b0, 8'h12, 8'h34);

    // Reset while two pixels are in flight.
    pix(1'b1, 1'b0, 8'h11, 8'h22);
    pix(1'b1, 1'b0, 8'h33, 8'h44);
    rst_n = 1'b0;
    flush_model();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix(1'b1, 1'b0, 8'hF0, 8'h0F);
    pix(1'b1, 1'b0, 8'hF0, 8'h0F);

    // Random traffic on both instances.
    for (int i = 0; i < 220; i++) begin
      logic [AW-1:0] l;
      l = AW'($urandom);
      pix($urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0, l,
          ($urandom_range(0, 5) == 0) ? ~l : AW'($urandom));
    end

    b_en = 1'b0;
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, '0, '0);

    n_tests++;
    if (expa_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_a got %0d outstanding want 0", expa_q.size());
    end
    n_tests++;
    if (expb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_b got %0d outstanding want 0", expb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
